// File: rtl/ram_pkg.sv
// Shared constants and helpers for the multi-channel arbitrated RAM.
package ram_pkg;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int DEF_DW = 8;
  localparam int DEF_KB = 16;

  // Low bit of channel i's slice in a flattened per-channel bus of width w.
  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Flattened per-channel request/response bundle between requesters and the shared RAM.
interface ram_arbiter_if #(
  parameter int CH = 2,
  parameter int AW = 14,
  parameter int DW = 8
);
  logic              busy;
  logic [CH-1:0]     req;
  logic [CH-1:0]     we;
  logic [CH*AW-1:0]  a;
  logic [CH*DW-1:0]  d;
  logic [CH-1:0]     ack;
  logic [CH-1:0]     valid;
  logic [CH*DW-1:0]  q;

  modport slave  (input req, we, a, d, output busy, ack, valid, q);
  modport master (output req, we, a, d, input busy, ack, valid, q);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant generator; searches from the pointer and advances it past each winner.
module rr_arbiter #(
  parameter  int CH = 2,
  localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [CH-1:0] req,
  output logic [CH-1:0] grant,
  output logic [PW-1:0] gidx
);
  logic [PW-1:0] r_ptr;
  logic          w_found;
  int            w_idx;

  always_comb begin
    grant   = '0;
    gidx    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < CH; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= CH) w_idx = w_idx - CH;
      if (enable && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        gidx         = PW'(w_idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_ptr <= '0;
    else if (w_found)
      r_ptr <= (int'(gidx) + 1 >= CH) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Single-port block RAM shared by CH requesters: round-robin access, per-channel
// read registers with a valid strobe, optional zero-fill after reset.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter  int KB    = DEF_KB,
  parameter  int DW    = DEF_DW,
  parameter  int CH    = 2,
  parameter  bit CLEAR = 1'b1,
  localparam int DEPTH = KB * 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = (CH > 1) ? $clog2(CH) : 1
) (
  input logic         clock,
  input logic         reset,
  ram_arbiter_if.slave bus
);
  logic [DW-1:0]  r_mem [DEPTH];
  logic [0:0]     r_state;
  logic [AW-1:0]  r_cnt;
  logic [CH-1:0]  r_valid;
  logic [DW-1:0]  r_q [CH];

  logic [CH-1:0]  w_gnt;
  logic [PW-1:0]  w_gidx;
  logic           w_any;
  logic           w_rd;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_wdata;
  logic [DW-1:0]  w_rdata;

  rr_arbiter #(.CH(CH)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (r_state == ST_RUN && !reset),
    .req    (bus.req),
    .grant  (w_gnt),
    .gidx   (w_gidx)
  );

  assign w_any   = |w_gnt;
  assign w_rd    = bus.we[w_gidx];
  assign w_addr  = bus.a[slice_lo(int'(w_gidx), AW) +: AW];
  assign w_wdata = bus.d[slice_lo(int'(w_gidx), DW) +: DW];
  assign w_rdata = r_mem[w_addr];

  assign bus.ack   = w_gnt;
  assign bus.busy  = (r_state == ST_CLEAR);
  assign bus.valid = r_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR ? ST_CLEAR : ST_RUN;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(DEPTH - 1)) r_state <= ST_RUN;
    end
  end

  // The array itself carries no reset; only the fill sequence and granted writes touch it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == ST_CLEAR)
        r_mem[r_cnt] <= '0;
      else if (w_any && !w_rd)
        r_mem[w_addr] <= w_wdata;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid[i] <= 1'b0;
        r_q[i]     <= '0;
      end else begin
        r_valid[i] <= w_gnt[i] & w_rd;
        if (w_gnt[i] && w_rd) r_q[i] <= w_rdata;
      end
    end
    assign bus.q[i*DW +: DW] = r_q[i];
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with KB=1, DW=8, CH=3, CLEAR=1.
module tb_ram_arbiter;
  localparam int KB = 1;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.CH(CH), .AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.KB(KB), .DW(DW), .CH(CH), .CLEAR(1'b1)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int i, input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.we[i]          = wen;
    bus.a[i*AW +: AW]  = addr;
    bus.d[i*DW +: DW]  = data;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      if (bus.ack !== 3'b000) bad++;
      tick();
      n++;
    end
    chk({tag, "_len"}, n, 1024);
    chk({tag, "_ack0"}, bad, 0);
  endtask

  initial begin
    bus.req = '0;
    bus.we  = '1;
    bus.a   = '0;
    bus.d   = '0;
    // Reads held on all channels from reset onward.
    set_ch(0, 1'b1, 10'h3FF, 8'h00);
    set_ch(1, 1'b1, 10'h000, 8'h00);
    set_ch(2, 1'b1, 10'h001, 8'h00);
    bus.req = 3'b111;
    tick();
    tick();
    chk("rst_busy",  bus.busy,  1);
    chk("rst_ack",   bus.ack,   3'b000);
    chk("rst_valid", bus.valid, 3'b000);
    chk("rst_q",     bus.q,     24'h0);

    // Reset in the middle of the fill restarts it.
    rst = 1'b0;
    repeat (500) tick();
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    chk("mrst_busy",  bus.busy,  1);
    chk("mrst_valid", bus.valid, 3'b000);
    chk("mrst_q",     bus.q,     24'h0);
    rst = 1'b0;
    wait_clear("clear");

    // First grant lands the cycle busy falls, starting from ch0.
    #1 chk("rr0", bus.ack, 3'b001);
    tick();
    chk("clr_valid", bus.valid, 3'b001);
    chk("clr_q0",    bus.q[7:0], 8'h00);
    #1 chk("rr1", bus.ack, 3'b010);
    tick();
    #1 chk("rr2", bus.ack, 3'b100);
    tick();
    #1 chk("rr3", bus.ack, 3'b001);
    tick();
    #1 chk("rr4", bus.ack, 3'b010);
    tick();
    #1 chk("rr5", bus.ack, 3'b100);
    tick();

    // ch0 read of location 0 after the fill.
    bus.req = 3'b001;
    set_ch(0, 1'b1, 10'h000, 8'h00);
    #1 chk("rd0_ack", bus.ack, 3'b001);
    tick();
    chk("rd0_valid", bus.valid, 3'b001);
    chk("rd0_q",     bus.q[7:0], 8'h00);

    // Write then read through another channel.
    set_ch(0, 1'b0, 10'h123, 8'hA5);
    #1 chk("wr_ack", bus.ack, 3'b001);
    tick();
    chk("wr_valid", bus.valid, 3'b000);
    bus.req = 3'b010;
    set_ch(1, 1'b1, 10'h123, 8'h00);
    #1 chk("rd1_ack", bus.ack, 3'b010);
    tick();
    chk("rd1_valid", bus.valid, 3'b010);
    chk("rd1_q1",    bus.q[15:8], 8'hA5);
    chk("rd1_q0",    bus.q[7:0],  8'h00);

    // Pointer is 2 here; one ch0 grant moves it to 1.
    bus.req = 3'b001;
    set_ch(0, 1'b1, 10'h000, 8'h00);
    tick();
    bus.req = 3'b101;
    #1 chk("alt0", bus.ack, 3'b100);
    tick();
    #1 chk("alt1", bus.ack, 3'b001);
    tick();
    #1 chk("alt2", bus.ack, 3'b100);
    tick();
    #1 chk("alt3", bus.ack, 3'b001);
    tick();

    // Pointer is 1; a ch2 grant brings it back to 0.
    bus.req = 3'b100;
    tick();
    bus.req = 3'b011;
    set_ch(0, 1'b0, 10'h010, 8'h5A);
    set_ch(1, 1'b1, 10'h010, 8'h00);
    #1 chk("col_ack0", bus.ack, 3'b001);
    tick();
    bus.req = 3'b010;
    #1 chk("col_ack1", bus.ack, 3'b010);
    tick();
    bus.req = 3'b000;
    chk("col_valid", bus.valid, 3'b010);
    chk("col_q1",    bus.q[15:8], 8'h5A);
    chk("run_busy",  bus.busy, 0);

    // A pending read result is wiped by reset.
    bus.req = 3'b100;
    set_ch(2, 1'b1, 10'h010, 8'h00);
    tick();
    bus.req = 3'b000;
    chk("rd2_valid", bus.valid, 3'b100);
    chk("rd2_q2",    bus.q[23:16], 8'h5A);
    rst = 1'b1;
    tick();
    chk("rrd_valid", bus.valid, 3'b000);
    chk("rrd_q",     bus.q, 24'h0);
    chk("rrd_busy",  bus.busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
